// File: rtl/processador_pkg.sv
// Shared definitions for the 16-bit multi-cycle processor: opcodes, step
// encodings, bus source selects and instruction field positions.
package processador_pkg;

   localparam int DATA_W = 16;
   localparam int NREGS  = 8;

   localparam logic [2:0] OP_MV  = 3'b000;
   localparam logic [2:0] OP_ADD = 3'b001;
   localparam logic [2:0] OP_SUB = 3'b010;
   localparam logic [2:0] OP_AND = 3'b011;
   localparam logic [2:0] OP_OUT = 3'b100;
   localparam logic [2:0] OP_MVI = 3'b101;

   // Low bit of each instruction field; op/rX/rY are 3 bits wide.
   localparam int OP_LSB = 13;
   localparam int RX_LSB = 10;
   localparam int RY_LSB = 7;
   localparam int IMM_W  = 10;

   typedef enum logic [1:0] {T0, T1, T2, T3} step_t;

   typedef enum logic [2:0] {SEL_ZERO, SEL_RX, SEL_RY, SEL_IMM, SEL_G} bus_sel_t;

   function automatic logic [DATA_W-1:0] alu(input logic [2:0] op,
                                             input logic [DATA_W-1:0] a,
                                             input logic [DATA_W-1:0] b);
      case (op)
         OP_ADD:  alu = a + b;
         OP_SUB:  alu = a - b;
         OP_AND:  alu = a & b;
         default: alu = '0;
      endcase
   endfunction

endpackage

// File: rtl/processador_if.sv
// Instruction input and observable data bus of the processor.
interface processador_if;
   import processador_pkg::*;

   logic [DATA_W-1:0] iin;
   logic [DATA_W-1:0] bus;

   modport master (output iin, input bus);
   modport slave  (input iin, output bus);
endinterface

// File: rtl/processador_regn.sv
// Generic register with synchronous active-high reset and load enable.
module regn #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         srst,
   input  logic         ld,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] q_reg;

   always_ff @(posedge clk) begin
      if (srst)
         q_reg <= '0;
      else if (ld)
         q_reg <= d;
   end

   assign q = q_reg;

endmodule

// File: rtl/processador.sv
// Multi-cycle processor: 4-step counter, decode/control and the shared data
// bus feeding R0..R7, A, G and IR.
module processador
   import processador_pkg::*;
(
   input  logic         clock,
   input  logic         resetn,
   processador_if.slave io
);

   step_t             step_reg;
   logic [DATA_W-1:0] r_q [NREGS];
   logic [DATA_W-1:0] ir_q, a_q, g_q;
   logic [DATA_W-1:0] bus_w, alu_w;
   logic [NREGS-1:0]  r_ld;
   logic              a_ld, g_ld, ir_ld;
   bus_sel_t          sel;
   logic [2:0]        op, rx, ry;

   assign op = ir_q[OP_LSB +: 3];
   assign rx = ir_q[RX_LSB +: 3];
   assign ry = ir_q[RY_LSB +: 3];

   always_ff @(posedge clock) begin
      if (resetn)
         step_reg <= T0;
      else
         step_reg <= step_t'(step_reg + 2'd1);
   end

   // Unknown opcodes fall through every case to the nop defaults.
   always_comb begin
      sel   = SEL_ZERO;
      r_ld  = '0;
      a_ld  = 1'b0;
      g_ld  = 1'b0;
      ir_ld = 1'b0;
      case (step_reg)
         T0: ir_ld = 1'b1;
         T1: begin
            case (op)
               OP_MV:  begin sel = SEL_RY;  r_ld[rx] = 1'b1; end
               OP_MVI: begin sel = SEL_IMM; r_ld[rx] = 1'b1; end
               OP_OUT: sel = SEL_RX;
               OP_ADD, OP_SUB, OP_AND: begin sel = SEL_RX; a_ld = 1'b1; end
               default: sel = SEL_ZERO;
            endcase
         end
         T2: begin
            case (op)
               OP_ADD, OP_SUB, OP_AND: begin sel = SEL_RY; g_ld = 1'b1; end
               OP_OUT: sel = SEL_RX;
               default: sel = SEL_ZERO;
            endcase
         end
         T3: begin
            case (op)
               OP_ADD, OP_SUB, OP_AND: begin sel = SEL_G; r_ld[rx] = 1'b1; end
               OP_OUT: sel = SEL_RX;
               default: sel = SEL_ZERO;
            endcase
         end
         default: sel = SEL_ZERO;
      endcase
   end

   always_comb begin
      bus_w = '0;
      if (!resetn) begin
         case (sel)
            SEL_RX:  bus_w = r_q[rx];
            SEL_RY:  bus_w = r_q[ry];
            SEL_IMM: bus_w = {{(DATA_W-IMM_W){1'b0}}, ir_q[IMM_W-1:0]};
            SEL_G:   bus_w = g_q;
            default: bus_w = '0;
         endcase
      end
   end

   assign alu_w  = alu(op, a_q, bus_w);
   assign io.bus = bus_w;

   generate
      for (genvar gi = 0; gi < NREGS; gi++) begin : g_regs
         regn #(.W(DATA_W)) u_r (
            .clk  (clock),
            .srst (resetn),
            .ld   (r_ld[gi]),
            .d    (bus_w),
            .q    (r_q[gi])
         );
      end
   endgenerate

   regn #(.W(DATA_W)) u_ir (
      .clk(clock), .srst(resetn), .ld(ir_ld), .d(io.iin), .q(ir_q)
   );

   regn #(.W(DATA_W)) u_a (
      .clk(clock), .srst(resetn), .ld(a_ld), .d(bus_w), .q(a_q)
   );

   regn #(.W(DATA_W)) u_g (
      .clk(clock), .srst(resetn), .ld(g_ld), .d(alu_w), .q(g_q)
   );

endmodule

// File: tb/tb_processador.sv
// Scoreboard bench: each slot queues its expected per-step bus values and a
// negedge monitor compares the bus against the queue head.
`timescale 1ns/1ps
module tb_processador;

   logic clock = 1'b1;
   logic resetn;
   always #5 clock = ~clock;

   processador_if io ();

   processador dut (
      .clock  (clock),
      .resetn (resetn),
      .io     (io.slave)
   );

   logic [15:0] exp_q [$];
   string       name_q [$];
   int          vectors = 0;
   int          miscompares = 0;

   task automatic push(input logic [15:0] v, input string nm);
      exp_q.push_back(v);
      name_q.push_back(nm);
   endtask

   always @(negedge clock) begin
      if (exp_q.size() > 0) begin
         logic [15:0] e;
         string       n;
         e = exp_q.pop_front();
         n = name_q.pop_front();
         vectors++;
         if (io.bus !== e) begin
            miscompares++;
            $display("FAIL %s: bus=%h expected %h", n, io.bus, e);
         end else begin
            $display("ok   %s: bus=%h", n, io.bus);
         end
      end
   end

   task automatic do_reset(input int n);
      resetn = 1'b1;
      for (int i = 0; i < n; i++) push(16'h0000, "reset");
      repeat (n) @(posedge clock);
      #1;
      resetn = 1'b0;
   endtask

   task automatic run_slot(input logic [15:0] instr, input logic [15:0] b1,
                           input logic [15:0] b2, input logic [15:0] b3,
                           input string nm);
      io.iin = instr;
      push(16'h0000, $sformatf("%s T0", nm));
      push(b1, $sformatf("%s T1", nm));
      push(b2, $sformatf("%s T2", nm));
      push(b3, $sformatf("%s T3", nm));
      repeat (4) @(posedge clock);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      io.iin = 16'h0000;
      do_reset(2);

      run_slot(16'hA01C, 16'd28,   16'd0,   16'd0,   "mvi R0,28");
      run_slot(16'h8000, 16'd28,   16'd28,  16'd28,  "out R0");
      run_slot(16'hA40A, 16'd10,   16'd0,   16'd0,   "mvi R1,10");
      run_slot(16'h2080, 16'd28,   16'd10,  16'd38,  "add R0,R1");
      run_slot(16'h8000, 16'd38,   16'd38,  16'd38,  "out R0");

      run_slot(16'hA805, 16'd5,    16'd0,   16'd0,   "mvi R2,5");
      run_slot(16'hAC07, 16'd7,    16'd0,   16'd0,   "mvi R3,7");
      run_slot(16'h4980, 16'd5,    16'd7,   16'hFFFE, "sub R2,R3");
      run_slot(16'h8800, 16'hFFFE, 16'hFFFE, 16'hFFFE, "out R2");
      run_slot(16'h2900, 16'hFFFE, 16'hFFFE, 16'hFFFC, "add R2,R2");

      run_slot(16'h1C00, 16'd38,   16'd0,   16'd0,   "mv R7,R0");
      run_slot(16'h9C00, 16'd38,   16'd38,  16'd38,  "out R7");
      run_slot(16'h7C80, 16'd38,   16'd10,  16'd2,   "and R7,R1");
      run_slot(16'h9C00, 16'd2,    16'd2,   16'd2,   "out R7");

      run_slot(16'hB3FF, 16'h03FF, 16'd0,   16'd0,   "mvi R4,1023");
      run_slot(16'hE000, 16'd0,    16'd0,   16'd0,   "op111");
      run_slot(16'hC000, 16'd0,    16'd0,   16'd0,   "op110");
      run_slot(16'h8000, 16'd38,   16'd38,  16'd38,  "out R0 kept");
      run_slot(16'h8400, 16'd10,   16'd10,  16'd10,  "out R1 kept");
      run_slot(16'h9000, 16'h03FF, 16'h03FF, 16'h03FF, "out R4");

      // Reset asserted during T2 of add R5,R6 must abort the write-back.
      run_slot(16'hB409, 16'd9,    16'd0,   16'd0,   "mvi R5,9");
      run_slot(16'hB803, 16'd3,    16'd0,   16'd0,   "mvi R6,3");
      io.iin = 16'h3700;
      push(16'h0000, "add R5,R6 T0");
      push(16'd9,    "add R5,R6 T1");
      repeat (2) @(posedge clock);
      #1;
      do_reset(2);
      run_slot(16'h9400, 16'd0,    16'd0,   16'd0,   "out R5 after reset");
      run_slot(16'h8000, 16'd0,    16'd0,   16'd0,   "out R0 after reset");
      run_slot(16'hA40A, 16'd10,   16'd0,   16'd0,   "mvi R1,10 post");
      run_slot(16'h8400, 16'd10,   16'd10,  16'd10,  "out R1 post");

      repeat (2) @(negedge clock);
      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
